tmux_4to1: RTL and testbench

//   Four-input, one-hot-select AND-OR multiplexer for the CPU datapath (operand/result select).
//   - Combinational path: result = the source named by the one-hot sel.
//   - Registered copy of result plus a select-error flag, for pipeline-stage use.
//   - No encoded-select decoding: the caller drives one-hot sel directly.

---
 rtl/tmux_4to1.sv | 47 ++++
 tb/tb_tmux_4to1.sv | 119 +++++++++++
 2 files changed

// File: rtl/tmux_4to1.sv
// rtl/tmux_4to1.sv - one-hot AND-OR 4:1 mux with registered result and select-error flag
module tmux_4to1 #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic [WIDTH-1:0] i_src3,
    input  logic [WIDTH-1:0] i_src4,
    input  logic [3:0]       i_sel,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_q,
    output logic             o_sel_err_q
);

    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_sel_minus1;
    logic             w_onehot;
    logic [WIDTH-1:0] r_result;
    logic             r_sel_err;

    // No priority: multi-hot selects OR their sources together.
    assign w_result = ({WIDTH{i_sel[0]}} & i_src1)
                    | ({WIDTH{i_sel[1]}} & i_src2)
                    | ({WIDTH{i_sel[2]}} & i_src3)
                    | ({WIDTH{i_sel[3]}} & i_src4);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_sel_minus1 = i_sel - 4'd1;
    assign w_onehot     = (i_sel != 4'd0) && ((i_sel & w_sel_minus1) == 4'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_result  <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_result  <= w_result;
            r_sel_err <= ~w_onehot;
        end
    end

    assign o_result    = w_result;
    assign o_result_q  = r_result;
    assign o_sel_err_q = r_sel_err;

endmodule

// File: tb/tb_tmux_4to1.sv
// tb/tb_tmux_4to1.sv - directed self-checking bench for tmux_4to1
module tb_tmux_4to1;

    logic        clk;
    logic        rst;
    logic [31:0] src1, src2, src3, src4;
    logic [3:0]  sel;
    logic [31:0] result, result_q;
    logic        sel_err_q;

    int errors = 0;
    int checks = 0;

    tmux_4to1 #(.WIDTH(32)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_src1      (src1),
        .i_src2      (src2),
        .i_src3      (src3),
        .i_src4      (src4),
        .i_sel       (sel),
        .o_result    (result),
        .o_result_q  (result_q),
        .o_sel_err_q (sel_err_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; registered outputs are sampled 1 ns after the next.
    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  sel_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] exp_tab [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] prev;

    initial begin
        rst = 1'b1;
        src1 = 32'd1; src2 = 32'd2; src3 = 32'd3; src4 = 32'd4;
        sel = 4'b0000;
        step_edge();
        check("reset_result_q", result_q, 32'd0);
        check("reset_sel_err", {31'd0, sel_err_q}, 32'd0);
        rst = 1'b0;

        // Zero select
        #1;
        check("zero_sel_result", result, 32'd0);
        step_edge();
        check("zero_sel_result_q", result_q, 32'd0);
        check("zero_sel_err", {31'd0, sel_err_q}, 32'd1);

        // Each one-hot select
        for (int i = 0; i < 4; i++) begin
            sel = sel_tab[i];
            #1;
            check($sformatf("onehot%0d_result", i), result, exp_tab[i]);
            step_edge();
            check($sformatf("onehot%0d_result_q", i), result_q, exp_tab[i]);
            check($sformatf("onehot%0d_sel_err", i), {31'd0, sel_err_q}, 32'd0);
        end

        // Multi-hot ORs sources and flags
        src1 = 32'h0F0; src3 = 32'h00F; sel = 4'b0101;
        #1;
        check("multi_result", result, 32'h0FF);
        step_edge();
        check("multi_result_q", result_q, 32'h0FF);
        check("multi_sel_err", {31'd0, sel_err_q}, 32'd1);

        // Async reset with result_q = 4 and error flag set
        src1 = 32'd0; src4 = 32'd4; sel = 4'b1001;
        step_edge();
        check("pre_rst_result_q", result_q, 32'd4);
        check("pre_rst_sel_err", {31'd0, sel_err_q}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_result_q", result_q, 32'd0);
        check("async_rst_sel_err", {31'd0, sel_err_q}, 32'd0);
        check("rst_comb_result", result, 32'd4);
        step_edge();
        check("hold_rst_result_q", result_q, 32'd0);
        check("hold_rst_sel_err", {31'd0, sel_err_q}, 32'd0);
        rst = 1'b0;
        src1 = 32'd1; src2 = 32'd2; sel = 4'b0011;
        step_edge();
        check("post_rst_result_q", result_q, 32'd3);
        check("post_rst_sel_err", {31'd0, sel_err_q}, 32'd1);

        // Toggle src2 every cycle: combinational tracks, register lags one cycle
        sel = 4'b0010;
        prev = 32'd3;
        for (int i = 0; i < 6; i++) begin
            src2 = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            #1;
            check($sformatf("toggle%0d_result", i), result, src2);
            check($sformatf("toggle%0d_lag", i), result_q, prev);
            step_edge();
            check($sformatf("toggle%0d_result_q", i), result_q, src2);
            prev = src2;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
